// File: rtl/mdu_pkg.sv
// Shared opcodes, FSM states and decode helpers for the multiply/divide unit.
// The ALU control unit imports the same opcode constants from here.
package mdu_pkg;

    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;
    localparam logic [4:0] OP_MTHI  = 5'h14;
    localparam logic [4:0] OP_MTLO  = 5'h15;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed(input logic [4:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the control path and the multiply/divide unit.
// master: start, aluopctrl, a, b out; busy, done, hi, lo in. slave: mirrored.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       aluopctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, aluopctrl, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, aluopctrl, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on a {rem,quo} shift pair.
// Ports: rem_in/quo_in/divisor in; rem_out/quo_out out (all WIDTH bits).
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);
    logic [WIDTH:0]   part;
    logic [WIDTH-1:0] diff;

    always_comb begin
        part = {rem_in, quo_in[WIDTH-1]};
        // part - divisor < divisor when it fits, so WIDTH bits suffice
        diff = part[WIDTH-1:0] - divisor;
        if (part >= {1'b0, divisor}) begin
            rem_out = diff;
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_out = part[WIDTH-1:0];
            quo_out = {quo_in[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO and one-cycle MTHI/MTLO.
// Ports: clk, rst_n (async low), bus (mdu_if.slave: start/aluopctrl/a/b in; busy/done/hi/lo out).
// Option: MDU_EARLY_OUT_EN ends multiply CALC once remaining multiplier bits are zero.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst_n,
    mdu_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;
    logic               div_op, neg_q, neg_r;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [4:0]         op;
    logic               sgn, req_md, req_mt, b_zero, calc_last;
    logic [WIDTH-1:0]   a_abs, b_abs, rem_nx, quo_nx;

    assign op = bus.aluopctrl;

    always_comb begin
        sgn    = is_signed(op);
        req_md = bus.start && is_muldiv(op);
        req_mt = bus.start && (op == OP_MTHI || op == OP_MTLO);
        b_zero = (bus.b == '0);
        a_abs  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_abs  = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (acc[2*WIDTH-1:WIDTH]),
        .quo_in  (acc[WIDTH-1:0]),
        .divisor (opb),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

`ifdef MDU_EARLY_OUT_EN
    // multiplicand is shifted left, so acc stays aligned on early exit
    assign calc_last = (cnt == LAST) ||
                       (!div_op && opb[WIDTH-1:1] == '0);
`else
    assign calc_last = (cnt == LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_md)
                    state_d = (is_div(op) && b_zero) ? FIX : CALC;
                else if (req_mt)
                    state_d = DONE;
            end
            CALC:    if (calc_last) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            opb    <= '0;
            div_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_md) begin
                        cnt    <= '0;
                        div_op <= is_div(op);
                        opb    <= b_abs;
                        neg_q  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1])
                                  & ~(is_div(op) & b_zero);
                        neg_r  <= sgn & is_div(op) & bus.a[WIDTH-1] & ~b_zero;
                        mcand  <= {{WIDTH{1'b0}}, a_abs};
                        if (!is_div(op))
                            acc <= '0;
                        else if (b_zero)
                            // FIX passes this straight to hi/lo
                            acc <= {bus.a, {WIDTH{1'b1}}};
                        else
                            acc <= {{WIDTH{1'b0}}, a_abs};
                    end else if (req_mt) begin
                        if (op == OP_MTHI) hi_q <= bus.a;
                        else               lo_q <= bus.a;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (div_op) begin
                        acc <= {rem_nx, quo_nx};
                    end else begin
                        if (opb[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        opb   <= opb >> 1;
                    end
                end
                FIX: begin
                    if (div_op) begin
                        hi_q <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        lo_q <= neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        {hi_q, lo_q} <= neg_q ? -acc : acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q == CALC) || (state_q == FIX);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed and random self-checking bench for mdu_seq.
// Drives mdu_if at negedge, samples 1ns after posedge.
module tb_mdu_seq;
    import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    mdu_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int early, input int full);
        return EARLY ? early : full;
    endfunction

    function automatic int mul_calc(input logic [31:0] m);
        int t;
        t = 0;
        for (int i = 0; i < 32; i++) if (m[i]) t = i + 1;
        if (!EARLY) return 32;
        return (t < 1) ? 1 : t;
    endfunction

    task automatic launch(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluopctrl = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bc,
                             output logic [31:0] hi, output logic [31:0] lo);
        cyc = 1;
        bc = bus.busy ? 1 : 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) bc++;
        end
        hi = bus.hi;
        lo = bus.lo;
        check("done_seen", bus.done, 1);
        @(posedge clk);
        #1;
        check("done_pulse", bus.done, 0);
    endtask

    task automatic run(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc, output int bc,
                       output logic [31:0] hi, output logic [31:0] lo);
        launch(op, a, b);
        wait_done(cyc, bc, hi, lo);
    endtask

    initial begin
        int cyc, bc, sel;
        logic [31:0] hi, lo, a, b, ehi, elo, mb;
        logic [4:0] op;
        logic [63:0] p;
        logic signed [63:0] sa, sb, sq, sr;
        logic seen;
        int ecyc;

        bus.start = 1'b0;
        bus.aluopctrl = 5'h0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        @(negedge clk) rst_n = 1'b1;

        run(OP_MULTU, 32'hFFFFFFFF, 32'h2, cyc, bc, hi, lo);
        check("multu_hi", hi, 32'h1);
        check("multu_lo", lo, 32'hFFFFFFFE);
        check("multu_cyc", cyc, lat(4, 34));

        run(OP_MULT, 32'hFFFFFFFD, 32'd7, cyc, bc, hi, lo);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
        check("mult_busy", bc, lat(4, 33));
        check("mult_cyc", cyc, lat(5, 34));

        run(OP_MULT, 32'hFFFFFFFE, 32'hFFFFFFFD, cyc, bc, hi, lo);
        check("mult_nn_hi", hi, 32'h0);
        check("mult_nn_lo", lo, 32'h6);
        check("mult_nn_cyc", cyc, lat(4, 34));

        run(OP_DIV, 32'hFFFFFFF9, 32'd2, cyc, bc, hi, lo);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div_cyc", cyc, 34);

        run(OP_DIV, 32'd7, 32'hFFFFFFFE, cyc, bc, hi, lo);
        check("div_nb_lo", lo, 32'hFFFFFFFD);
        check("div_nb_hi", hi, 32'h1);

        run(OP_DIVU, 32'd100, 32'd7, cyc, bc, hi, lo);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run(OP_DIVU, 32'h1234, 32'h0, cyc, bc, hi, lo);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_cyc", cyc, 2);
        check("div0_busy", bc, 1);

        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, bc, hi, lo);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 32'h0);

        run(OP_MTHI, 32'hCAFE, 32'h0, cyc, bc, hi, lo);
        check("mthi_hi", hi, 32'hCAFE);
        check("mthi_lo", lo, 32'h80000000);
        check("mthi_cyc", cyc, 1);
        check("mthi_busy", bc, 0);

        run(OP_MTLO, 32'hBEEF, 32'h0, cyc, bc, hi, lo);
        check("mtlo_lo", lo, 32'hBEEF);
        check("mtlo_hi", hi, 32'hCAFE);

        launch(OP_MULTU, 32'd3, 32'd5);
        @(negedge clk);
        bus.start = 1'b1;
        bus.aluopctrl = OP_MTHI;
        bus.a = 32'hDEAD;
        bus.b = 32'hFFFF;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_start_hi", bus.hi, 32'hCAFE);
        wait_done(cyc, bc, hi, lo);
        check("busy_start_rhi", hi, 32'h0);
        check("busy_start_rlo", lo, 32'd15);

        launch(OP_MULT, 32'd12345, 32'd6789);
        repeat (8) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        @(negedge clk) rst_n = 1'b1;
        run(OP_MULT, 32'd6, 32'd7, cyc, bc, hi, lo);
        check("post_rst_lo", lo, 32'd42);
        check("post_rst_hi", hi, 32'd0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.aluopctrl = 5'h00;
        bus.a = 32'hFFFF;
        @(negedge clk) bus.aluopctrl = 5'h16;
        @(negedge clk) bus.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 seen = seen | bus.done | bus.busy;
        end
        check("bad_op_idle", seen, 0);
        check("bad_op_lo", bus.lo, 32'd42);

        run(OP_MULTU, 32'h12345678, 32'h1, cyc, bc, hi, lo);
        check("mul1_lo", lo, 32'h12345678);
        check("mul1_hi", hi, 32'h0);
        check("mul1_cyc", cyc, lat(3, 34));

        for (int i = 0; i < 300 && bad == 0; i++) begin
            sel = $urandom_range(0, 3);
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) b = $urandom_range(0, 255);
            if (i % 11 == 0) b = 32'h0;
            case (sel)
                0: op = OP_MULT;
                1: op = OP_MULTU;
                2: op = OP_DIV;
                default: op = OP_DIVU;
            endcase
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            if (sel == 0) begin
                p = sa * sb;
                mb = b[31] ? -b : b;
                ecyc = mul_calc(mb) + 2;
            end else if (sel == 1) begin
                p = {32'h0, a} * {32'h0, b};
                ecyc = mul_calc(b) + 2;
            end else if (b == 32'h0) begin
                p = {a, 32'hFFFFFFFF};
                ecyc = 2;
            end else if (sel == 2) begin
                sq = sa / sb;
                sr = sa % sb;
                p = {sr[31:0], sq[31:0]};
                ecyc = 34;
            end else begin
                p = {a % b, a / b};
                ecyc = 34;
            end
            ehi = p[63:32];
            elo = p[31:0];
            run(op, a, b, cyc, bc, hi, lo);
            check("rand_hi", hi, ehi);
            check("rand_lo", lo, elo);
            check("rand_cyc", cyc, ecyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
